// File: rtl/fpu_operand_loader_if.sv
// Operand loader <-> FPU sequencer bus.
// master drives switches/enables, slave is the loader.
interface fpu_operand_loader_if;
    logic        start_raw;
    logic [15:0] data;
    logic        enaA;
    logic        enaB;
    logic        enaO;
    logic        enaR;
    logic [15:0] R;
    logic        clr;
    logic        start;
    logic [17:0] A;
    logic [17:0] B;
    logic [1:0]  O;
    logic [15:0] res_q;
    logic        a_vld;
    logic        b_vld;
    logic [1:0]  a_cls;
    logic [1:0]  b_cls;

    modport master (
        output start_raw, data, enaA, enaB,
        output enaO, enaR, R, clr,
        input  start, A, B, O, res_q,
        input  a_vld, b_vld, a_cls, b_cls
    );

    modport slave (
        input  start_raw, data, enaA, enaB,
        input  enaO, enaR, R, clr,
        output start, A, B, O, res_q,
        output a_vld, b_vld, a_cls, b_cls
    );
endinterface

// File: rtl/fpu_operand_loader.sv
// FPU front end: start conditioning, operand capture and unpack.
// Define FPU_LOADER_DEBOUNCE_EN to debounce the start button.
module fpu_operand_loader #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    fpu_operand_loader_if.slave bus
);

    logic s1;
    logic s2;
    logic lvl;
    logic prev;

    function automatic logic [17:0] unpack(
        input logic [15:0] w
    );
        logic [11:0] m;
        m = (w[14:10] == 5'd0) ? {2'b00, w[9:0]}
                               : {2'b01, w[9:0]};
        return {w[15], w[14:10], m};
    endfunction

    function automatic logic [1:0] classify(
        input logic [15:0] w
    );
        logic [1:0] c;
        c = 2'b00;
        if (w[14:10] == 5'h1f)
            c = (w[9:0] != 10'd0) ? 2'b11 : 2'b10;
        else if (w[14:10] == 5'd0 && w[9:0] == 10'd0)
            c = 2'b01;
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= bus.start_raw;
            s2   <= s1;
            prev <= lvl;
        end
    end

`ifdef FPU_LOADER_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt;
    logic             lvl_q;

    // lvl only follows s2 after DEB_CYCLES stable cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            lvl_q <= 1'b0;
        end else if (s2 == lvl_q) begin
            cnt <= '0;
        end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
            lvl_q <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s2;
`endif

    assign bus.start = lvl & ~prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.A     <= '0;
            bus.B     <= '0;
            bus.O     <= '0;
            bus.res_q <= '0;
            bus.a_cls <= '0;
            bus.b_cls <= '0;
        end else begin
            if (bus.enaA) begin
                bus.A     <= unpack(bus.data);
                bus.a_cls <= classify(bus.data);
            end
            if (bus.enaB) begin
                bus.B     <= unpack(bus.data);
                bus.b_cls <= classify(bus.data);
            end
            if (bus.enaO)
                bus.O <= bus.data[1:0];
            if (bus.enaR)
                bus.res_q <= bus.R;
        end
    end

    // a capture in the clr cycle wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.a_vld <= 1'b0;
            bus.b_vld <= 1'b0;
        end else begin
            if (bus.enaA)
                bus.a_vld <= 1'b1;
            else if (bus.clr)
                bus.a_vld <= 1'b0;
            if (bus.enaB)
                bus.b_vld <= 1'b1;
            else if (bus.clr)
                bus.b_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader.
// Vector table for captures, sequences for start/reset.
module tb_fpu_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;

    fpu_operand_loader_if bus ();

    fpu_operand_loader #(
        .DEB_CYCLES(8),
        .DEB_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef FPU_LOADER_DEBOUNCE_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        ea;
        logic        eb;
        logic        eo;
        logic        er;
        logic [15:0] r;
        logic        clr;
        logic [17:0] xa;
        logic [17:0] xb;
        logic [1:0]  xo;
        logic [15:0] xr;
        logic        xav;
        logic        xbv;
        logic [1:0]  xac;
        logic [1:0]  xbc;
    } vec_t;

    vec_t v [14];

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
    endtask

    task automatic check_all(
        input string tag, input vec_t e
    );
        check({tag, " A"}, 32'(bus.A), 32'(e.xa));
        check({tag, " B"}, 32'(bus.B), 32'(e.xb));
        check({tag, " O"}, 32'(bus.O), 32'(e.xo));
        check({tag, " res_q"}, 32'(bus.res_q), 32'(e.xr));
        check({tag, " a_vld"}, 32'(bus.a_vld), 32'(e.xav));
        check({tag, " b_vld"}, 32'(bus.b_vld), 32'(e.xbv));
        check({tag, " a_cls"}, 32'(bus.a_cls), 32'(e.xac));
        check({tag, " b_cls"}, 32'(bus.b_cls), 32'(e.xbc));
    endtask

    task automatic idle();
        bus.enaA = 1'b0;
        bus.enaB = 1'b0;
        bus.enaO = 1'b0;
        bus.enaR = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic press(
        input  int len,
        input  int win,
        output int n,
        output int first
    );
        n = 0;
        first = -1;
        bus.start_raw = 1'b1;
        for (int i = 0; i < win; i++) begin
            @(posedge clk);
            #1;
            if (bus.start) begin
                n++;
                if (first < 0) first = i;
            end
            if (i == len - 1) bus.start_raw = 1'b0;
        end
    endtask

    vec_t zero;
    vec_t hold;
    int   n;
    int   first;

    initial begin
        bus.start_raw = 1'b0;
        bus.data      = '0;
        bus.R         = '0;
        idle();
        zero = '0;

        v[0]  = '{16'h3C00, 1,0,0,0, 16'h0000, 0,
                  18'h0F400, 18'h00000, 2'd0, 16'h0000,
                  1, 0, 2'b00, 2'b00};
        v[1]  = '{16'hC000, 0,1,0,0, 16'h0000, 0,
                  18'h0F400, 18'h30400, 2'd0, 16'h0000,
                  1, 1, 2'b00, 2'b00};
        v[2]  = '{16'h0001, 1,0,0,0, 16'h0000, 0,
                  18'h00001, 18'h30400, 2'd0, 16'h0000,
                  1, 1, 2'b00, 2'b00};
        v[3]  = '{16'h8000, 1,0,0,0, 16'h0000, 0,
                  18'h20000, 18'h30400, 2'd0, 16'h0000,
                  1, 1, 2'b01, 2'b00};
        v[4]  = '{16'h7C00, 1,0,0,0, 16'h0000, 0,
                  18'h1F400, 18'h30400, 2'd0, 16'h0000,
                  1, 1, 2'b10, 2'b00};
        v[5]  = '{16'h7E00, 0,1,0,0, 16'h0000, 0,
                  18'h1F400, 18'h1F600, 2'd0, 16'h0000,
                  1, 1, 2'b10, 2'b11};
        v[6]  = '{16'h0000, 0,0,0,0, 16'h0000, 1,
                  18'h1F400, 18'h1F600, 2'd0, 16'h0000,
                  0, 0, 2'b10, 2'b11};
        v[7]  = '{16'h3C00, 1,0,0,0, 16'h0000, 1,
                  18'h0F400, 18'h1F600, 2'd0, 16'h0000,
                  1, 0, 2'b00, 2'b11};
        v[8]  = '{16'h0000, 0,0,0,1, 16'h4200, 0,
                  18'h0F400, 18'h1F600, 2'd0, 16'h4200,
                  1, 0, 2'b00, 2'b11};
        v[9]  = '{16'h0003, 0,0,1,0, 16'h0000, 0,
                  18'h0F400, 18'h1F600, 2'd3, 16'h4200,
                  1, 0, 2'b00, 2'b11};
        v[10] = '{16'h4002, 1,1,1,0, 16'h0000, 0,
                  18'h10402, 18'h10402, 2'd2, 16'h4200,
                  1, 1, 2'b00, 2'b00};
        v[11] = '{16'h0000, 0,0,0,0, 16'h1234, 0,
                  18'h10402, 18'h10402, 2'd2, 16'h4200,
                  1, 1, 2'b00, 2'b00};
        v[12] = '{16'h0000, 0,1,0,0, 16'h0000, 1,
                  18'h10402, 18'h00000, 2'd2, 16'h4200,
                  0, 1, 2'b00, 2'b01};
        v[13] = '{16'h0000, 0,0,0,1, 16'hBEEF, 0,
                  18'h10402, 18'h00000, 2'd2, 16'hBEEF,
                  0, 1, 2'b00, 2'b01};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero);
        check("reset start", 32'(bus.start), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            bus.data = v[i].data;
            bus.enaA = v[i].ea;
            bus.enaB = v[i].eb;
            bus.enaO = v[i].eo;
            bus.enaR = v[i].er;
            bus.R    = v[i].r;
            bus.clr  = v[i].clr;
            @(posedge clk);
            #1;
            idle();
            check_all($sformatf("vec%0d", i), v[i]);
        end

        // enable held 3 cycles keeps the last word
        bus.enaA = 1'b1;
        bus.data = 16'h3C00;
        @(posedge clk);
        #1;
        bus.data = 16'h4000;
        @(posedge clk);
        #1;
        bus.data = 16'h4400;
        @(posedge clk);
        #1;
        idle();
        bus.data = 16'h7E00;
        @(posedge clk);
        #1;
        hold = v[13];
        hold.xa  = 18'h11400;
        hold.xav = 1'b1;
        check_all("hold", hold);

        press(20, 40, n, first);
        check("press1 count", 32'(n), 32'd1);
        check("press1 lat", 32'(first), 32'(LAT));
        press(20, 40, n, first);
        check("press2 count", 32'(n), 32'd1);
        check("press2 lat", 32'(first), 32'(LAT));

`ifdef FPU_LOADER_DEBOUNCE_EN
        press(5, 40, n, first);
        check("glitch count", 32'(n), 32'd0);
        press(12, 40, n, first);
        check("press12 count", 32'(n), 32'd1);
        check("press12 lat", 32'(first), 32'(LAT));
`else
        press(1, 10, n, first);
        check("short count", 32'(n), 32'd1);
        check("short lat", 32'(first), 32'(LAT));
`endif

        // async reset mid-cycle with registers loaded
        bus.start_raw = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_all("midrst", zero);
        check("midrst start", 32'(bus.start), 32'd0);
        bus.start_raw = 1'b0;
        @(posedge clk);
        #1;
        check("midrst held start", 32'(bus.start), 32'd0);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
